// File: rtl/snn_noc_pkg.sv
// Shared types for the spike-to-packet path: sequencer states, config table
// selectors and packet field widths.
package snn_noc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_EMIT   = 2'd2
    } state_t;

    localparam logic [1:0] CFG_NADDR = 2'd0;
    localparam logic [1:0] CFG_PTR   = 2'd1;
    localparam logic [1:0] CFG_DOWN  = 2'd2;
    localparam logic [1:0] CFG_RSVD  = 2'd3;

    localparam int PKT_ADDR_W = 12;
    localparam int PKT_W      = 2 * PKT_ADDR_W;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority encoder: lowest requesting index at or above start,
// wrapping to the lowest requesting index overall.
module rr_arbiter #(
    parameter int N     = 10,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    logic [IDX_W-1:0] wrap_idx_s;
    logic             hit_s;

    // Descending scans leave the lowest qualifying index in the result
    always_comb begin
        wrap_idx_s = '0;
        grant      = '0;
        hit_s      = 1'b0;
        valid      = |req;
        for (int m = N - 1; m >= 0; m--) begin
            wrap_idx_s = req[m] ? IDX_W'(m) : wrap_idx_s;
        end
        for (int m = N - 1; m >= 0; m--) begin
            grant = (req[m] && (m >= int'(start))) ? IDX_W'(m) : grant;
            hit_s = (req[m] && (m >= int'(start))) ? 1'b1 : hit_s;
        end
        grant = hit_s ? grant : wrap_idx_s;
    end

endmodule

// File: rtl/spike_packetizer.sv
// Turns per-neuron spike strobes into {source, destination} packets by
// walking a CSR-style connection table for each pending neuron.
module spike_packetizer
    import snn_noc_pkg::*;
#(
    parameter int N_NEURONS = 10,
    parameter int ADDR_W    = PKT_ADDR_W,
    parameter int MAX_CONN  = 30,
    parameter int PTR_W     = $clog2(MAX_CONN + 1)
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  clear,
    input  logic [N_NEURONS-1:0]  spikes,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_sel,
    input  logic [PTR_W-1:0]      cfg_idx,
    input  logic [ADDR_W-1:0]     cfg_data,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic [2*ADDR_W-1:0]   pkt_data,
    output logic                  busy,
    output logic                  cfg_err
);

    localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [PTR_W-1:0] MAX_PTR = PTR_W'(MAX_CONN);

    logic [ADDR_W-1:0]     naddr_r [N_NEURONS];
    logic [PTR_W-1:0]      ptr_r   [N_NEURONS+1];
    logic [ADDR_W-1:0]     down_r  [MAX_CONN];

    state_t                state_r;
    logic [N_NEURONS-1:0]  pending_r, pending_nxt_s;
    logic [IDX_W-1:0]      rr_ptr_r, cur_r, gnt_idx_s, rr_next_s;
    logic                  gnt_valid_s;
    logic [PTR_W-1:0]      j_r, end_r, ptr_lo_s, ptr_hi_s, j_start_s, end_s, j_next_s, down_idx_s;
    logic [ADDR_W-1:0]     naddr_sel_s, down_rd_s;
    logic                  bad_ptr_s, cfg_ok_s, serve_done_s;
    logic                  flush_r, pkt_valid_r, cfg_err_r;
    logic [2*ADDR_W-1:0]   pkt_data_r;

    rr_arbiter #(.N(N_NEURONS), .IDX_W(IDX_W)) u_arb (
        .req   (pending_r),
        .start (rr_ptr_r),
        .grant (gnt_idx_s),
        .valid (gnt_valid_s)
    );

    // Tables are only writable while nothing is queued or in flight
    always_comb begin
        cfg_ok_s = 1'b0;
        if (cfg_we && (state_r == ST_IDLE) && (pending_r == '0)) begin
            case (cfg_sel)
                CFG_NADDR: cfg_ok_s = (int'(cfg_idx) < N_NEURONS);
                CFG_PTR:   cfg_ok_s = (int'(cfg_idx) < N_NEURONS + 1);
                CFG_DOWN:  cfg_ok_s = (int'(cfg_idx) < MAX_CONN);
                default:   cfg_ok_s = 1'b0;
            endcase
        end else begin
            cfg_ok_s = 1'b0;
        end
    end

    // Table read muxes for the neuron being served
    always_comb begin
        naddr_sel_s = '0;
        ptr_lo_s    = '0;
        ptr_hi_s    = '0;
        down_rd_s   = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            naddr_sel_s = (int'(cur_r) == k) ? naddr_r[k]   : naddr_sel_s;
            ptr_lo_s    = (int'(cur_r) == k) ? ptr_r[k]     : ptr_lo_s;
            ptr_hi_s    = (int'(cur_r) == k) ? ptr_r[k + 1] : ptr_hi_s;
        end
        for (int k = 0; k < MAX_CONN; k++) begin
            down_rd_s = (int'(down_idx_s) == k) ? down_r[k] : down_rd_s;
        end
    end

    // Clamping keeps j and end inside the downstream table
    assign j_start_s  = (ptr_lo_s > MAX_PTR) ? MAX_PTR : ptr_lo_s;
    assign end_s      = (ptr_hi_s > MAX_PTR) ? MAX_PTR : ptr_hi_s;
    assign bad_ptr_s  = (ptr_hi_s > MAX_PTR);
    assign j_next_s   = j_r + PTR_W'(1);
    assign down_idx_s = (state_r == ST_EMIT) ? j_next_s : j_start_s;
    assign rr_next_s  = (int'(cur_r) == N_NEURONS - 1) ? '0 : cur_r + IDX_W'(1);

    assign serve_done_s = ((state_r == ST_LOOKUP) && !clear && (j_start_s >= end_s)) ||
                          ((state_r == ST_EMIT) && pkt_ready && !clear && !flush_r &&
                           (j_next_s == end_r));

    // Pending bits: clear flushes everything, a fresh spike beats a served-clear
    always_comb begin
        pending_nxt_s = pending_r;
        if (clear) begin
            pending_nxt_s = '0;
        end else begin
            if (serve_done_s) begin
                pending_nxt_s[cur_r] = 1'b0;
            end else begin
                pending_nxt_s = pending_r;
            end
            pending_nxt_s = pending_nxt_s | spikes;
        end
    end

    // Config table storage
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int k = 0; k < N_NEURONS; k++)     naddr_r[k] <= '0;
            for (int k = 0; k < N_NEURONS + 1; k++) ptr_r[k]   <= '0;
            for (int k = 0; k < MAX_CONN; k++)      down_r[k]  <= '0;
        end else begin
            for (int k = 0; k < N_NEURONS; k++)
                if (cfg_ok_s && (cfg_sel == CFG_NADDR) && (int'(cfg_idx) == k)) naddr_r[k] <= cfg_data;
            for (int k = 0; k < N_NEURONS + 1; k++)
                if (cfg_ok_s && (cfg_sel == CFG_PTR) && (int'(cfg_idx) == k)) ptr_r[k] <= cfg_data[PTR_W-1:0];
            for (int k = 0; k < MAX_CONN; k++)
                if (cfg_ok_s && (cfg_sel == CFG_DOWN) && (int'(cfg_idx) == k)) down_r[k] <= cfg_data;
        end
    end

    // Sequencer: arbitration, connection walk and registered packet outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r     <= ST_IDLE;
            pending_r   <= '0;
            rr_ptr_r    <= '0;
            cur_r       <= '0;
            j_r         <= '0;
            end_r       <= '0;
            flush_r     <= 1'b0;
            pkt_valid_r <= 1'b0;
            pkt_data_r  <= '0;
            cfg_err_r   <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s;
            cfg_err_r <= (cfg_we && !cfg_ok_s) || ((state_r == ST_LOOKUP) && bad_ptr_s);
            case (state_r)
                ST_IDLE: begin
                    flush_r <= 1'b0;
                    if (gnt_valid_s && !clear) begin
                        cur_r   <= gnt_idx_s;
                        state_r <= ST_LOOKUP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOOKUP: begin
                    if (clear) begin
                        state_r <= ST_IDLE;
                    end else if (j_start_s >= end_s) begin
                        rr_ptr_r <= rr_next_s;
                        state_r  <= ST_IDLE;
                    end else begin
                        j_r         <= j_start_s;
                        end_r       <= end_s;
                        pkt_valid_r <= 1'b1;
                        pkt_data_r  <= {naddr_sel_s, down_rd_s};
                        state_r     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (pkt_ready) begin
                        if (clear || flush_r || (j_next_s == end_r)) begin
                            if (!clear && !flush_r) rr_ptr_r <= rr_next_s;
                            pkt_valid_r <= 1'b0;
                            pkt_data_r  <= '0;
                            state_r     <= ST_IDLE;
                        end else begin
                            j_r        <= j_next_s;
                            pkt_data_r <= {naddr_sel_s, down_rd_s};
                        end
                    end else if (clear) begin
                        flush_r <= 1'b1;
                    end
                end
                default: begin
                    pkt_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign pkt_valid = pkt_valid_r;
    assign pkt_data  = pkt_data_r;
    assign cfg_err   = cfg_err_r;
    assign busy      = (state_r != ST_IDLE) || (|pending_r);

endmodule

// File: tb/tb_spike_packetizer.sv
// Directed bench for spike_packetizer: inputs driven 1ns after each rising
// edge, outputs checked at the same point.
module tb_spike_packetizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [9:0]  spikes;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [4:0]  cfg_idx;
    logic [11:0] cfg_data;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [23:0] pkt_data;
    logic        busy;
    logic        cfg_err;

    int n_checks = 0;
    int n_fails  = 0;
    int n_pkts;
    logic [23:0] got [0:63];
    logic [11:0] acc;

    spike_packetizer dut (
        .CLK(clk), .RESET_N(rst_n), .clear(clear), .spikes(spikes),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
        .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_wr(input logic [1:0] sel, input int idx, input logic [11:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_idx = 5'(idx); cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    // Record every packet that will be accepted at the next edge
    task automatic collect(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            if (pkt_valid && pkt_ready && n < 64) begin
                got[n] = pkt_data;
                n++;
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; spikes = '0; cfg_we = 1'b0;
        cfg_sel = 2'd0; cfg_idx = 5'd0; cfg_data = 12'd0; pkt_ready = 1'b1;
        #3;
        chk("rst_valid", 64'(pkt_valid), 64'd0);
        chk("rst_data", 64'(pkt_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cfg_err", 64'(cfg_err), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // table setup
        cfg_wr(2'd0, 0, 12'h100);  cfg_wr(2'd0, 2, 12'h202);
        cfg_wr(2'd0, 3, 12'hA03);  cfg_wr(2'd0, 9, 12'h909);
        cfg_wr(2'd1, 1, 12'd2);    cfg_wr(2'd1, 2, 12'd1);
        cfg_wr(2'd1, 3, 12'd4);    cfg_wr(2'd1, 4, 12'd6);
        cfg_wr(2'd1, 9, 12'd6);    cfg_wr(2'd1, 10, 12'd7);
        chk("cfg_ok_ptr10", 64'(cfg_err), 64'd0);
        cfg_wr(2'd2, 0, 12'hD00);  cfg_wr(2'd2, 1, 12'hD01);
        cfg_wr(2'd2, 2, 12'hD02);  cfg_wr(2'd2, 3, 12'hD03);
        cfg_wr(2'd2, 4, 12'h111);  cfg_wr(2'd2, 5, 12'h222);
        cfg_wr(2'd2, 6, 12'h666);
        chk("cfg_ok_down", 64'(cfg_err), 64'd0);
        cfg_wr(2'd3, 0, 12'h555);
        chk("cfg_err_rsvd", 64'(cfg_err), 64'd1);
        cfg_wr(2'd0, 10, 12'h555);
        chk("cfg_err_naddr_idx", 64'(cfg_err), 64'd1);
        cfg_wr(2'd1, 11, 12'd3);
        chk("cfg_err_ptr_idx", 64'(cfg_err), 64'd1);
        tick();
        chk("cfg_err_drop", 64'(cfg_err), 64'd0);

        // round robin: neurons 0 and 9 together, rr_ptr starts at 0
        spikes = 10'h201; tick(); spikes = '0;
        collect(20, n_pkts);
        chk("rr1_count", 64'(n_pkts), 64'd3);
        chk("rr1_p0", 64'(got[0]), 64'h100D00);
        chk("rr1_p1", 64'(got[1]), 64'h100D01);
        chk("rr1_p2", 64'(got[2]), 64'h909666);
        spikes = 10'h201; tick(); spikes = '0;
        collect(20, n_pkts);
        chk("rr2_count", 64'(n_pkts), 64'd3);
        chk("rr2_first_n0", 64'(got[0]), 64'h100D00);
        chk("rr2_last_n9", 64'(got[2]), 64'h909666);

        // latency and full-throughput pair for neuron 3
        spikes = 10'h008; tick(); spikes = '0;
        chk("lat_busy_k", 64'(busy), 64'd1);
        chk("lat_valid_k", 64'(pkt_valid), 64'd0);
        tick();
        chk("lat_valid_k1", 64'(pkt_valid), 64'd0);
        tick();
        chk("lat_valid_k2", 64'(pkt_valid), 64'd1);
        chk("lat_data_k2", 64'(pkt_data), 64'hA03111);
        tick();
        chk("tp_valid_k3", 64'(pkt_valid), 64'd1);
        chk("tp_data_k3", 64'(pkt_data), 64'hA03222);
        tick();
        chk("tp_valid_k4", 64'(pkt_valid), 64'd0);
        chk("tp_busy_k4", 64'(busy), 64'd0);

        // backpressure hold
        pkt_ready = 1'b0;
        spikes = 10'h008; tick(); spikes = '0;
        tick(); tick();
        chk("bp_data0", 64'(pkt_data), 64'hA03111);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_hold_valid", 64'(pkt_valid), 64'd1);
            chk("bp_hold_data", 64'(pkt_data), 64'hA03111);
        end
        pkt_ready = 1'b1;
        tick();
        chk("bp_next_valid", 64'(pkt_valid), 64'd1);
        chk("bp_next_data", 64'(pkt_data), 64'hA03222);
        tick();
        chk("bp_done", 64'(pkt_valid), 64'd0);

        // config write while emitting is rejected
        pkt_ready = 1'b0;
        spikes = 10'h008; tick(); spikes = '0;
        tick(); tick();
        cfg_wr(2'd0, 3, 12'hFFF);
        chk("emit_cfg_err", 64'(cfg_err), 64'd1);
        tick();
        chk("emit_cfg_err_pulse", 64'(cfg_err), 64'd0);
        pkt_ready = 1'b1;
        collect(10, n_pkts);
        chk("emit_cfg_count", 64'(n_pkts), 64'd2);
        chk("emit_cfg_p1", 64'(got[1]), 64'hA03222);

        // clear during emit of a 3-connection neuron
        spikes = 10'h004; tick(); spikes = '0;
        tick(); tick();
        chk("clr_first", 64'(pkt_data), 64'h202D01);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_valid", 64'(pkt_valid), 64'd0);
        collect(10, n_pkts);
        chk("clr_no_more", 64'(n_pkts), 64'd0);
        chk("clr_busy", 64'(busy), 64'd0);

        // clear suppresses a same-cycle spike
        spikes = 10'h008; clear = 1'b1; tick(); spikes = '0; clear = 1'b0;
        chk("clr_spike_busy", 64'(busy), 64'd0);
        collect(6, n_pkts);
        chk("clr_spike_pkts", 64'(n_pkts), 64'd0);

        // empty connection range
        cfg_wr(2'd1, 5, 12'd7); cfg_wr(2'd1, 6, 12'd7);
        spikes = 10'h020; tick(); spikes = '0;
        chk("empty_busy_k", 64'(busy), 64'd1);
        tick();
        chk("empty_busy_k1", 64'(busy), 64'd1);
        tick();
        chk("empty_busy_k2", 64'(busy), 64'd0);
        chk("empty_valid", 64'(pkt_valid), 64'd0);

        // malformed end pointer
        cfg_wr(2'd1, 9, 12'd31); cfg_wr(2'd1, 10, 12'd31);
        spikes = 10'h200; tick(); spikes = '0;
        tick(); tick();
        chk("badptr_err", 64'(cfg_err), 64'd1);
        chk("badptr_valid", 64'(pkt_valid), 64'd0);

        // asynchronous reset mid-emit
        tick();
        pkt_ready = 1'b0;
        spikes = 10'h008; tick(); spikes = '0;
        tick(); tick();
        chk("arst_pre_valid", 64'(pkt_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(pkt_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        acc = '0;
        for (int k = 0; k < 10; k++) acc = acc | dut.naddr_r[k];
        chk("arst_naddr_zero", 64'(acc), 64'd0);
        acc = '0;
        for (int k = 0; k < 11; k++) acc = acc | 12'(dut.ptr_r[k]);
        chk("arst_ptr_zero", 64'(acc), 64'd0);
        acc = '0;
        for (int k = 0; k < 30; k++) acc = acc | dut.down_r[k];
        chk("arst_down_zero", 64'(acc), 64'd0);
        pkt_ready = 1'b1;
        spikes = 10'h3FF; tick(); spikes = '0;
        collect(40, n_pkts);
        chk("arst_no_pkts", 64'(n_pkts), 64'd0);
        chk("arst_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/spike_packetizer.md
SPIKE_PACKETIZER -- requirements
Module: spike_packetizer

Interface
REQ-001 SHALL have parameter N_NEURONS, default 10, number of local neurons and spike inputs.
REQ-002 SHALL have parameter ADDR_W, default 12, neuron/destination address width.
REQ-003 SHALL have parameter MAX_CONN, default 30, downstream-connection table depth.
REQ-004 SHALL have parameter PTR_W, default clog2(MAX_CONN+1), connection-pointer width.
REQ-005 SHALL have ports, in order:
  - CLK  in  1  single clock; all state on rising edge.
  - RESET_N  in  1  reset, asynchronous, active-low.
  - clear  in  1  timestep start; synchronous pending flush.
  - spikes  in  N_NEURONS  per-neuron spike strobes, bit i = neuron i.
  - cfg_we  in  1  config write strobe.
  - cfg_sel  in  2  target table: 0 = neuron address, 1 = connection pointer, 2 = downstream connection, 3 = reserved.
  - cfg_idx  in  PTR_W  table index.
  - cfg_data  in  ADDR_W  write data; pointer writes use the low PTR_W bits.
  - pkt_valid  out  1  packet available.
  - pkt_ready  in  1  downstream accepts.
  - pkt_data  out  2*ADDR_W  {source neuron address, destination address}.
  - busy  out  1  FSM not IDLE or any pending bit set.
  - cfg_err  out  1  one-cycle pulse on a rejected config write or a malformed pointer.

Function
REQ-006 Tables SHALL be: neuron address, N_NEURONS entries; pointer, N_NEURONS+1 entries (CSR row pointers); downstream, MAX_CONN entries.
REQ-007 A config write SHALL take effect at the edge where cfg_we=1, only if state=IDLE and pending=0; otherwise it is dropped and cfg_err pulses.
REQ-008 A config write with cfg_idx out of range for the selected table, or with cfg_sel=3, SHALL be dropped and cfg_err pulses.
REQ-009 pending[i] SHALL set at any edge where spikes[i]=1, and stay set until neuron i has been fully served.
REQ-010 If spikes[i] rises in the same cycle pending[i] is cleared, set SHALL win and neuron i is served again.
REQ-011 The FSM SHALL have states IDLE, LOOKUP and EMIT.
REQ-012 IDLE -> LOOKUP when pending!=0 and clear=0; selects the lowest set index i at or above rr_ptr, wrapping round-robin.
REQ-013 LOOKUP SHALL load j=ptr[i] and end=min(ptr[i+1],MAX_CONN).
  - If j>=end: clear pending[i], set rr_ptr=i+1 mod N_NEURONS, return to IDLE, emit nothing.
  - If ptr[i+1]>MAX_CONN: pulse cfg_err.
REQ-014 In EMIT, pkt_data SHALL equal {naddr[i], down[j]} and pkt_valid=1.
REQ-015 pkt_data and pkt_valid SHALL stay stable until the edge with pkt_valid&pkt_ready.
REQ-016 On an EMIT handshake: j++; if j+1==end, clear pending[i], set rr_ptr=i+1, go to IDLE; else remain in EMIT with the next packet on the following cycle (one packet per cycle at full throughput).
REQ-017 Latency: a spike sampled at edge k SHALL give pkt_valid=1 after edge k+2 when the FSM is IDLE with nothing else pending.
REQ-018 clear=1 SHALL clear all pending bits at that edge and suppress new spikes that same cycle.
REQ-019 If clear=1 in LOOKUP, the FSM SHALL return to IDLE.
REQ-020 If clear=1 in EMIT, the current packet SHALL complete its handshake, then the FSM goes to IDLE with no further packets.
REQ-021 Pointer arithmetic SHALL be unsigned PTR_W-bit; j never exceeds MAX_CONN.

Reset
REQ-022 While RESET_N=0, the block SHALL hold: state=IDLE, pending=0, rr_ptr=0, pkt_valid=0, pkt_data=0, busy=0, cfg_err=0, all table entries 0.
REQ-023 Reset assertion mid-EMIT SHALL drop pkt_valid immediately, without waiting for a clock edge.

Structure
REQ-024 Package snn_noc_pkg SHALL hold the FSM state enum, cfg_sel encodings and the packet field widths.
REQ-025 A sub-module rr_arbiter (N-bit round-robin priority encoder: request vector plus start pointer -> grant index and valid) SHALL be used.

Verification
REQ-026 Default params, naddr[3]=0xA03, ptr[3]=4, ptr[4]=6, down[4]=0x111, down[5]=0x222; spikes=0x008 one cycle, pkt_ready=1 -> pkt_data 0xA03111 then 0xA03222 on consecutive cycles, first valid after edge k+2.
REQ-027 Same setup with pkt_ready=0 for 5 cycles -> pkt_data held at 0xA03111 with pkt_valid=1 throughout, then both packets are delivered once ready rises.
REQ-028 spikes=0x201 with rr_ptr=0 -> all of neuron 0's packets, then all of neuron 9's; a second 0x201 spike -> neuron 0 served again.
REQ-029 ptr[5]=ptr[6]=7, spikes bit 5 -> no packet emitted, busy returns to 0 in 3 cycles.
REQ-030 Config write during EMIT -> cfg_err pulses once and the table is unchanged; clear during EMIT of a 3-connection neuron -> exactly 1 packet emitted.
REQ-031 RESET_N low mid-EMIT -> pkt_valid=0 immediately; after release, all tables read back 0.
